// File: rtl/instr_fetcher_pkg.sv
// rtl/instr_fetcher_pkg.sv - shared opcode constants, FSM states and J-immediate decode for the fetcher
package instr_fetcher_pkg;

    // RV32 major opcode of JAL, the only control transfer predicted in the front end
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } fetch_state_e;

    // Sign-extended J-type immediate: {i[31], i[19:12], i[20], i[30:21], 0}
    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetcher_next_pc_calc.sv
// rtl/instr_fetcher_next_pc_calc.sv - static next-PC prediction (JAL taken, everything else falls through)
import instr_fetcher_pkg::*;

module instr_fetcher_next_pc_calc (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] next_pc,
    output logic        pred_jump
);

    // JAL targets are known from the word itself; all other flow is corrected later by a RoB flush
    always_comb begin
        pred_jump = (instr[6:0] == OP_JAL);
        next_pc   = pred_jump ? (pc + j_imm(instr)) : (pc + 32'd4);
    end

endmodule

// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - single-outstanding-request instruction fetch unit with JAL prediction
import instr_fetcher_pkg::*;

module instr_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        icache_req_valid,
    output logic [31:0] icache_req_addr,
    input  logic        icache_ready,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_addr_out,
    output logic        pred_jump,
    input  logic        instr_issued
);

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  instr_out_n, instr_addr_n;
    logic         instr_valid_n, pred_jump_n;
    logic [31:0]  calc_pc;
    logic         calc_pj;

    instr_fetcher_next_pc_calc u_next_pc_calc (
        .pc        (pc),
        .instr     (icache_resp_data),
        .next_pc   (calc_pc),
        .pred_jump (calc_pj)
    );

    // Request is a pure function of state, so a frozen (rdy=0) fetcher keeps presenting the same request
    assign icache_req_valid = (state == S_REQ);
    assign icache_req_addr  = (state == S_REQ) ? {pc[31:2], 2'b00} : 32'h0;

    // State and output registers; reset overrides everything, rdy=0 is handled by next-state holding
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            instr_valid    <= 1'b0;
            instr_out      <= 32'h0;
            instr_addr_out <= 32'h0;
            pred_jump      <= 1'b0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            instr_valid    <= instr_valid_n;
            instr_out      <= instr_out_n;
            instr_addr_out <= instr_addr_n;
            pred_jump      <= pred_jump_n;
        end
    end

    // Next-state logic: flush beats the normal sequence; a flush while a request is in flight must drain it
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_valid_n = instr_valid;
        instr_out_n   = instr_out;
        instr_addr_n  = instr_addr_out;
        pred_jump_n   = pred_jump;
        if (rdy) begin
            if (flush) begin
                pc_n          = flush_pc;
                instr_valid_n = 1'b0;
                pred_jump_n   = 1'b0;
                if ((state == S_WAIT || state == S_DRAIN) && icache_resp_valid) begin
                    // The in-flight response lands in this very cycle and is dropped, nothing left to drain
                    state_n = S_REQ;
                end else if (state == S_WAIT || state == S_DRAIN ||
                             (state == S_REQ && icache_ready)) begin
                    state_n = S_DRAIN;
                end else begin
                    state_n = S_REQ;
                end
            end else begin
                case (state)
                    S_IDLE: state_n = S_REQ;
                    S_REQ: begin
                        if (icache_ready) state_n = S_WAIT;
                    end
                    S_WAIT: begin
                        if (icache_resp_valid) begin
                            instr_out_n   = icache_resp_data;
                            instr_addr_n  = pc;
                            instr_valid_n = 1'b1;
                            pc_n          = calc_pc;
                            pred_jump_n   = calc_pj;
                            state_n       = S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (instr_issued) begin
                            instr_valid_n = 1'b0;
                            state_n       = S_REQ;
                        end
                    end
                    S_DRAIN: begin
                        if (icache_resp_valid) state_n = S_REQ;
                    end
                    default: state_n = S_IDLE;
                endcase
            end
        end
    end

    // A response with no request outstanding indicates a cache protocol error
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            assert (!(icache_resp_valid && state != S_WAIT && state != S_DRAIN))
                else $error("instr_fetcher: icache response with no request outstanding");
        end
    end

endmodule

// File: tb/tb_instr_fetcher.sv
// tb/tb_instr_fetcher.sv - self-checking bench with cache model and fetch-stream reference model
module tb_instr_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_ready = 1'b0;
    logic        icache_resp_valid = 1'b0;
    logic [31:0] icache_resp_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_addr_out;
    logic        pred_jump;
    logic        instr_issued = 1'b0;

    instr_fetcher #(.RESET_PC(32'h0)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_ready      (icache_ready),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_data  (icache_resp_data),
        .instr_valid       (instr_valid),
        .instr_out         (instr_out),
        .instr_addr_out    (instr_addr_out),
        .pred_jump         (pred_jump),
        .instr_issued      (instr_issued)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cycle = 0;

    // Program memory: word, whether it is a JAL, and the address delta to the next fetched instruction
    logic [31:0] mem   [logic [31:0]];
    int          delta [logic [31:0]];
    bit          isjal [logic [31:0]];

    bit          cache_pend = 1'b0;
    int          cache_cnt = 0;
    logic [31:0] cache_addr = 32'h0;
    int          ready_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          issue_en = 1'b0;

    logic [31:0] ref_pc = 32'h0;
    bit          prev_flush = 1'b0;
    bit          s_fire, s_issue;
    logic [31:0] s_req_addr, s_instr_addr, s_instr_data;
    bit          s_pred;

    logic [31:0] cap_req[$];
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    bit          cap_pred[$];
    int          cap_time[$];

    function automatic logic [31:0] enc_jal(input int off);
        logic [31:0] o;
        o = off;
        return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'h6f};
    endfunction

    function automatic void set_word(input logic [31:0] a, input logic [31:0] w, input bit j, input int d);
        mem[a]   = w;
        isjal[a] = j;
        delta[a] = d;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] w;
        int          off;
        if (!mem.exists(a)) begin
            if ($urandom_range(0, 3) == 0) begin
                off = ($urandom_range(0, 32) - 16) * 4;
                set_word(a, enc_jal(off), 1'b1, off);
            end else begin
                w = $urandom;
                case ($urandom_range(0, 3))
                    0: w[6:0] = 7'h13;
                    1: w[6:0] = 7'h67;
                    2: w[6:0] = 7'h63;
                    default: w[6:0] = 7'h33;
                endcase
                set_word(a, w, 1'b0, 4);
            end
        end
        return mem[a];
    endfunction

    function automatic logic [31:0] next_of(input logic [31:0] a);
        return a + 32'(delta[a]);
    endfunction

    // One clock: drive cache/decoder inputs, step the edge, then advance the cache and reference models
    task automatic tick();
        bit resp_s;
        icache_resp_valid = cache_pend && (cache_cnt == 0);
        icache_resp_data  = icache_resp_valid ? mem_rd(cache_addr) : $urandom;
        icache_ready      = rdy && ($urandom_range(0, 99) < ready_pct);
        instr_issued      = issue_en && instr_valid;
        resp_s       = icache_resp_valid;
        s_fire       = icache_req_valid && icache_ready && rdy && !rst;
        s_req_addr   = icache_req_addr;
        s_issue      = instr_valid && instr_issued && rdy && !rst && !flush;
        s_instr_addr = instr_addr_out;
        s_instr_data = instr_out;
        s_pred       = pred_jump;
        prev_flush   = flush && rdy && !rst;
        @(posedge clk);
        #1;
        cycle++;
        if (rst) begin
            cache_pend = 1'b0;
            ref_pc     = 32'h0;
        end else begin
            if (cache_pend && cache_cnt > 0) cache_cnt--;
            if (rdy && resp_s) cache_pend = 1'b0;
            if (s_fire) begin
                cache_pend = 1'b1;
                cache_addr = s_req_addr;
                cache_cnt  = $urandom_range(lat_min, lat_max);
            end
            if (prev_flush) ref_pc = flush_pc;
            else if (s_issue) ref_pc = next_of(ref_pc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; issue_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        mem.delete(); delta.delete(); isjal.delete();
        ref_pc = 32'h0;
        prev_flush = 1'b0;
        ready_pct = 100; lat_min = 0; lat_max = 0;
    endtask

    task automatic run_capture(input int n_req);
        do_reset();
        for (int a = 0; a < 16; a += 4) set_word(a, 32'h00000013, 1'b0, 4);
        set_word(32'h10, 32'h0100006F, 1'b1, 16);
        set_word(32'h20, 32'h00000013, 1'b0, 4);
        cap_req.delete(); cap_addr.delete(); cap_data.delete(); cap_pred.delete(); cap_time.delete();
        issue_en = 1'b1;
        for (int i = 0; i < 80 && cap_req.size() < n_req; i++) begin
            tick();
            if (s_fire) cap_req.push_back(s_req_addr);
            if (s_issue) begin
                cap_addr.push_back(s_instr_addr);
                cap_data.push_back(s_instr_data);
                cap_pred.push_back(s_pred);
                cap_time.push_back(cycle);
            end
        end
        issue_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        issue_en = 1'b1;
        set_word(0, 32'h12345013, 1'b0, 4);
        repeat (6) tick();
        rst = 1'b1; rdy = 1'b0;
        tick();
        n_checks++;
        if ({icache_req_valid, icache_req_addr, instr_valid, instr_out, instr_addr_out, pred_jump} !== 99'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req_valid=%0b req_addr=%h valid=%0b instr=%h addr=%h pj=%0b, want all zero",
                     icache_req_valid, icache_req_addr, instr_valid, instr_out, instr_addr_out, pred_jump);
        end
        rst = 1'b0; rdy = 1'b1; issue_en = 1'b0;
        ref_pc = 32'h0;
        n_checks++;
        if (icache_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: req_valid=%0b, want 0 in the first cycle after reset", icache_req_valid);
        end
        tick();
        n_checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req: req_valid=%0b addr=%h, want 1 / 00000000", icache_req_valid, icache_req_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_req [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h20};
        run_capture(6);
        n_checks++;
        if (cap_req.size() < 6 || cap_addr.size() < 3) begin
            n_fail++;
            $display("FAIL seq_timeout: got %0d requests %0d issues, want >=6 / >=3", cap_req.size(), cap_addr.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (cap_req[i] !== exp_req[i]) begin
                    n_fail++;
                    $display("FAIL seq_req_addr[%0d]: got %h want %h", i, cap_req[i], exp_req[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (cap_addr[i] !== 32'(i * 4) || cap_pred[i] !== 1'b0 || cap_data[i] !== 32'h13) begin
                    n_fail++;
                    $display("FAIL seq_instr[%0d]: got addr=%h pj=%0b data=%h want %h/0/00000013",
                             i, cap_addr[i], cap_pred[i], cap_data[i], i * 4);
                end
            end
            n_checks++;
            if (cap_time[1] - cap_time[0] !== 3) begin
                n_fail++;
                $display("FAIL seq_throughput: got %0d cycles between issues want 3", cap_time[1] - cap_time[0]);
            end
        end
    endtask

    task automatic test_jal();
        run_capture(6);
        n_checks++;
        if (cap_addr.size() < 5 || cap_req.size() < 6) begin
            n_fail++;
            $display("FAIL jal_timeout: got %0d issues, want >=5", cap_addr.size());
        end else begin
            n_checks++;
            if (cap_addr[4] !== 32'h10 || cap_pred[4] !== 1'b1 || cap_data[4] !== 32'h0100006F) begin
                n_fail++;
                $display("FAIL jal_instr: got addr=%h pj=%0b data=%h want 00000010/1/0100006f",
                         cap_addr[4], cap_pred[4], cap_data[4]);
            end
            n_checks++;
            if (cap_req[5] !== 32'h20) begin
                n_fail++;
                $display("FAIL jal_target_req: got %h want 00000020", cap_req[5]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] o, a;
        do_reset();
        set_word(0, 32'h00500113, 1'b0, 4);
        set_word(4, 32'h00000013, 1'b0, 4);
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        n_checks++;
        if (instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_valid: instr_valid=%0b want 1 within 20 cycles", instr_valid);
        end
        o = instr_out; a = instr_addr_out;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_out !== 32'h00500113 || instr_addr_out !== 32'h0 ||
                instr_out !== o || instr_addr_out !== a || icache_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stable[%0d]: valid=%0b instr=%h addr=%h req=%0b want 1/00500113/00000000/0",
                         i, instr_valid, instr_out, instr_addr_out, icache_req_valid);
            end
        end
        issue_en = 1'b1;
        tick();
        issue_en = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || icache_req_valid !== 1'b1 || icache_req_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL bp_release: valid=%0b req=%0b addr=%h want 0/1/00000004",
                     instr_valid, icache_req_valid, icache_req_addr);
        end
    endtask

    task automatic test_flush_wait();
        bit found = 1'b0, bad = 1'b0, got = 1'b0;
        logic [31:0] ra = 32'h0;
        do_reset();
        for (int a = 0; a < 12; a += 4) set_word(a, 32'h00000013, 1'b0, 4);
        set_word(32'h100, 32'h00100093, 1'b0, 4);
        lat_min = 2; lat_max = 2;
        issue_en = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (s_fire && s_req_addr == 32'h8) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL fw_no_req8: request for 00000008 not seen, want seen");
        end
        flush = 1'b1; flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (instr_valid) bad = 1'b1;
            if (icache_req_valid) begin
                got = 1'b1;
                ra = icache_req_addr;
            end else tick();
        end
        n_checks++;
        if (bad || !got || ra !== 32'h100) begin
            n_fail++;
            $display("FAIL fw_redirect: stale_valid=%0b req_seen=%0b addr=%h want 0/1/00000100", bad, got, ra);
        end
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_addr_out !== 32'h100 || instr_out !== 32'h00100093) begin
            n_fail++;
            $display("FAIL fw_first_instr: valid=%0b addr=%h data=%h want 1/00000100/00100093",
                     instr_valid, instr_addr_out, instr_out);
        end
        issue_en = 1'b0;
    endtask

    task automatic test_flush_issue_collision();
        do_reset();
        set_word(0, 32'h00000013, 1'b0, 4);
        set_word(32'h40, 32'h00700193, 1'b0, 4);
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        flush = 1'b1; flush_pc = 32'h40; issue_en = 1'b1;
        tick();
        flush = 1'b0; issue_en = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || icache_req_valid !== 1'b1 || icache_req_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL collision: valid=%0b req=%0b addr=%h want 0/1/00000040",
                     instr_valid, icache_req_valid, icache_req_addr);
        end
        issue_en = 1'b1;
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        issue_en = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr_addr_out !== 32'h40 || instr_out !== 32'h00700193) begin
            n_fail++;
            $display("FAIL collision_instr: valid=%0b addr=%h data=%h want 1/00000040/00700193",
                     instr_valid, instr_addr_out, instr_out);
        end
    endtask

    task automatic test_rdy_stall();
        bit found = 1'b0;
        do_reset();
        set_word(0, 32'h00000013, 1'b0, 4);
        set_word(4, 32'h00A00093, 1'b0, 4);
        issue_en = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (s_fire && s_req_addr == 32'h4) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL stall_no_req4: request for 00000004 not seen, want seen");
        end
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (instr_valid !== 1'b0 || icache_req_valid !== 1'b0 || instr_addr_out !== 32'h0) begin
                n_fail++;
                $display("FAIL stall_frozen[%0d]: valid=%0b req=%0b addr=%h want 0/0/00000000",
                         i, instr_valid, icache_req_valid, instr_addr_out);
            end
        end
        rdy = 1'b1; issue_en = 1'b0;
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_addr_out !== 32'h4 || instr_out !== 32'h00A00093) begin
            n_fail++;
            $display("FAIL stall_resume: valid=%0b addr=%h data=%h want 1/00000004/00a00093",
                     instr_valid, instr_addr_out, instr_out);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_word(32'hFFFFFFFC, enc_jal(8), 1'b1, 8);
        set_word(32'h4, 32'h00000013, 1'b0, 4);
        tick();
        flush = 1'b1; flush_pc = 32'hFFFFFFFC;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_addr_out !== 32'hFFFFFFFC || pred_jump !== 1'b1 ||
            instr_out !== 32'h0080006F) begin
            n_fail++;
            $display("FAIL wrap_instr: valid=%0b addr=%h pj=%0b data=%h want 1/fffffffc/1/0080006f",
                     instr_valid, instr_addr_out, pred_jump, instr_out);
        end
        issue_en = 1'b1;
        tick();
        issue_en = 1'b0;
        n_checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL wrap_target: req=%0b addr=%h want 1/00000004", icache_req_valid, icache_req_addr);
        end
    endtask

    task automatic test_random();
        int delivered = 0;
        int errs = 0;
        logic [31:0] w;
        do_reset();
        ready_pct = 60; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 2500; i++) begin
            rdy      = ($urandom_range(0, 9) != 0);
            issue_en = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 49) == 0);
            flush_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 3) << 2))
                                                   : ($urandom & 32'hFFFFFFFC);
            if (prev_flush) begin
                n_checks++;
                if (instr_valid !== 1'b0) begin
                    n_fail++; errs++;
                    if (errs < 10) $display("FAIL rnd_flush_valid @%0d: valid=%0b want 0", cycle, instr_valid);
                end
            end
            if (icache_req_valid) begin
                n_checks++;
                if (icache_req_addr !== ref_pc) begin
                    n_fail++; errs++;
                    if (errs < 10) $display("FAIL rnd_req_addr @%0d: got %h want %h", cycle, icache_req_addr, ref_pc);
                end
            end
            if (instr_valid) begin
                w = mem_rd(ref_pc);
                n_checks++;
                if (instr_addr_out !== ref_pc || instr_out !== w || pred_jump !== isjal[ref_pc]) begin
                    n_fail++; errs++;
                    if (errs < 10)
                        $display("FAIL rnd_instr @%0d: got addr=%h data=%h pj=%0b want %h/%h/%0b",
                                 cycle, instr_addr_out, instr_out, pred_jump, ref_pc, w, isjal[ref_pc]);
                end
            end
            tick();
            if (s_issue) delivered++;
        end
        flush = 1'b0; rdy = 1'b1; issue_en = 1'b0;
        n_checks++;
        if (delivered < 50) begin
            n_fail++;
            $display("FAIL rnd_progress: delivered %0d instructions want >=50", delivered);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_sequential();
        test_jal();
        test_backpressure();
        test_flush_wait();
        test_flush_issue_collision();
        test_rdy_stall();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
